// File: rtl/combo_lut_pkg.sv
// Shared types and helpers for the combo_lut programmable gate.
package combo_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_LAST  = 2'd3
    } state_t;

    localparam int N_IN_MAX = 8;

    // Truth-table depth for an n-input gate.
    function automatic int tt_depth(input int n);
        return 32'sd1 << n;
    endfunction

endpackage

// File: rtl/combo_lut_loader.sv
// Serial truth-table loader: collects one bit per handshake into a shadow register
// and pulses commit (with the completed table) on the handshake carrying the last entry.
module combo_lut_loader
    import combo_lut_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_hs,
    input  logic                      cfg_bit,
    output logic                      commit,
    output logic [tt_depth(N_IN)-1:0] commit_data
);
    localparam int T = tt_depth(N_IN);
    localparam logic [N_IN-1:0] LAST_BIT = {N_IN{1'b1}};

    logic [T-1:0]    shadow_r;
    logic [N_IN-1:0] bit_cnt_r;

    // Commit pulse and the table as it will look once the final bit lands.
    always_comb begin
        commit      = 1'b0;
        commit_data = {cfg_bit, shadow_r[T-2:0]};
        if (cfg_hs && (bit_cnt_r == LAST_BIT)) begin
            commit = 1'b1;
        end else begin
            commit = 1'b0;
        end
    end

    // Shadow bits and entry counter advance once per accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r  <= '0;
            bit_cnt_r <= '0;
        end else if (cfg_hs) begin
            shadow_r[bit_cnt_r] <= cfg_bit;
            if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r + N_IN'(1'b1);
            end
        end
    end

endmodule

// File: rtl/combo_lut.sv
// combo_lut: registered programmable N_IN-input gate with serial table load and hardware sweep.
// Define COMBO_LUT_SIGNATURE_EN to add sig_ones, the count of 1-results over the last sweep.
module combo_lut
    import combo_lut_pkg::*;
#(
    parameter int                        N_IN    = 3,
    parameter logic [tt_depth(N_IN)-1:0] TT_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic            out_valid,
    output logic [N_IN-1:0] out_idx,
    output logic            out_y
`ifdef COMBO_LUT_SIGNATURE_EN
    ,
    output logic [N_IN:0]   sig_ones
`endif
);
    localparam int T = tt_depth(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    if ((N_IN < 1) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
        $error("combo_lut: N_IN out of range");
    end

    state_t          state_r, next_state_s;
    logic [T-1:0]    table_r;
    logic [N_IN-1:0] sweep_cnt_r;
    logic            cfg_ready_r, sweep_busy_r, sweep_done_r;
    logic            out_valid_r, out_y_r;
    logic [N_IN-1:0] out_idx_r;
    logic            cfg_hs_s, commit_s, eval_s, sweep_go_s;
    logic [T-1:0]    commit_data_s;

    assign cfg_hs_s = cfg_valid & cfg_ready_r;

    combo_lut_loader #(.N_IN(N_IN)) u_loader (
        .clk         (clk),
        .rst         (rst),
        .cfg_hs      (cfg_hs_s),
        .cfg_bit     (cfg_bit),
        .commit      (commit_s),
        .commit_data (commit_data_s)
    );

    // Evaluation only outside a sweep; a load handshake beats a same-cycle sweep request.
    always_comb begin
        eval_s     = 1'b0;
        sweep_go_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_LOAD)) begin
            eval_s     = in_valid;
            sweep_go_s = (state_r == ST_IDLE) & sweep_start & ~cfg_hs_s;
        end else begin
            eval_s     = 1'b0;
            sweep_go_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_hs_s) begin
                    next_state_s = ST_LOAD;
                end else if (sweep_go_s) begin
                    next_state_s = ST_SWEEP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (commit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_SWEEP: begin
                if (sweep_cnt_r == LAST_IDX) begin
                    next_state_s = ST_LAST;
                end else begin
                    next_state_s = ST_SWEEP;
                end
            end
            ST_LAST: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and state-derived status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cfg_ready_r  <= 1'b0;
            sweep_busy_r <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cfg_ready_r  <= (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD);
            sweep_busy_r <= (next_state_s == ST_SWEEP) || (next_state_s == ST_LAST);
            sweep_done_r <= (state_r == ST_SWEEP) && (sweep_cnt_r == LAST_IDX);
        end
    end

    // Active truth table; replaced in one shot when the loader commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_r <= TT_INIT;
        end else if (commit_s) begin
            table_r <= commit_data_s;
        end
    end

    // Sweep index: cleared when a sweep is accepted, walks 0..T-1 while sweeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt_r <= '0;
        end else if (sweep_go_s) begin
            sweep_cnt_r <= '0;
        end else if (state_r == ST_SWEEP) begin
            sweep_cnt_r <= sweep_cnt_r + N_IN'(1'b1);
        end
    end

    // Shared result register for both normal evaluation and sweep results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
            out_y_r     <= 1'b0;
        end else if (state_r == ST_SWEEP) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= sweep_cnt_r;
            out_y_r     <= table_r[sweep_cnt_r];
        end else if (eval_s) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= in_data;
            out_y_r     <= table_r[in_data];
        end else begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef COMBO_LUT_SIGNATURE_EN
    logic [N_IN:0] sig_ones_r;

    // Ones count over the sweep; settles as the last result is presented and then holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_ones_r <= '0;
        end else if (sweep_go_s) begin
            sig_ones_r <= '0;
        end else if (state_r == ST_SWEEP) begin
            sig_ones_r <= sig_ones_r + (N_IN + 1)'(table_r[sweep_cnt_r]);
        end
    end

    assign sig_ones = sig_ones_r;
`endif

    assign cfg_ready  = cfg_ready_r;
    assign sweep_busy = sweep_busy_r;
    assign sweep_done = sweep_done_r;
    assign out_valid  = out_valid_r;
    assign out_idx    = out_idx_r;
    assign out_y      = out_y_r;

endmodule

// File: tb/tb_combo_lut.sv
// Self-checking bench for combo_lut: directed vector tables, hand-written sweep/load sequences,
// and randomized traffic against a cycle-level reference model of the gate.
module tb_combo_lut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv, cv, cb, ss;
    logic [2:0] id;
    logic       ready, busy, done, ov, oy;
    logic [2:0] oidx;
    logic       iv1, id1, cv1, cb1, ss1;
    logic       ready1, busy1, done1, ov1, oy1, oidx1;
`ifdef COMBO_LUT_SIGNATURE_EN
    logic [3:0] sig;
    logic [1:0] sig1;
`endif

    int compared   = 0;
    int mismatched = 0;

    // reference model state (3-input instance)
    logic [7:0] m_tbl, m_shadow;
    int         m_cnt, m_sw, m_sig;
    logic       m_ready, m_busy, m_done, m_valid, m_y;
    logic [2:0] m_idx;

    typedef struct packed {
        logic [2:0] din;
        logic       y;
    } vec_t;
    vec_t vecs [8];

    combo_lut #(.N_IN(3), .TT_INIT(8'h00)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_data(id),
        .cfg_valid(cv), .cfg_bit(cb), .cfg_ready(ready),
        .sweep_start(ss), .sweep_busy(busy), .sweep_done(done),
        .out_valid(ov), .out_idx(oidx), .out_y(oy)
`ifdef COMBO_LUT_SIGNATURE_EN
        , .sig_ones(sig)
`endif
    );

    combo_lut #(.N_IN(1), .TT_INIT(2'b01)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1),
        .cfg_valid(cv1), .cfg_bit(cb1), .cfg_ready(ready1),
        .sweep_start(ss1), .sweep_busy(busy1), .sweep_done(done1),
        .out_valid(ov1), .out_idx(oidx1), .out_y(oy1)
`ifdef COMBO_LUT_SIGNATURE_EN
        , .sig_ones(sig1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tbl = 8'h00; m_shadow = 8'h00; m_cnt = 0; m_sw = -1; m_sig = 0;
        m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_y = 1'b0; m_idx = 3'd0;
    endtask

    // One clock edge of the gate, described by its observable rules.
    task automatic model_step(input logic s_iv, input logic [2:0] s_id,
                              input logic s_cv, input logic s_cb, input logic s_ss);
        logic hs;
        m_done = 1'b0;
        if (m_sw >= 0) begin
            m_sw++;
            if (m_sw <= 8) begin
                m_valid = 1'b1; m_idx = 3'(m_sw - 1); m_y = m_tbl[m_sw - 1];
                m_sig += int'(m_y); m_done = (m_sw == 8); m_busy = 1'b1; m_ready = 1'b0;
            end else begin
                m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_sw = -1;
            end
        end else begin
            hs = s_cv && m_ready;
            if (s_iv) begin
                m_valid = 1'b1; m_idx = s_id; m_y = m_tbl[s_id];
            end else begin
                m_valid = 1'b0;
            end
            m_busy = 1'b0; m_ready = 1'b1;
            if (hs) begin
                m_shadow[m_cnt] = s_cb;
                m_cnt++;
                if (m_cnt == 8) begin
                    m_tbl = m_shadow; m_cnt = 0;
                end
            end else if (s_ss && m_cnt == 0) begin
                m_sw = 0; m_busy = 1'b1; m_ready = 1'b0; m_sig = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("cfg_ready", ready, m_ready);
        chk("sweep_busy", busy, m_busy);
        chk("sweep_done", done, m_done);
        chk("out_valid", ov, m_valid);
        if (m_valid) begin
            chk("out_idx", oidx, m_idx);
            chk("out_y", oy, m_y);
        end
`ifdef COMBO_LUT_SIGNATURE_EN
        chk("sig_ones", sig, m_sig);
`endif
    endtask

    task automatic cyc(input logic a_iv, input logic [2:0] a_id,
                       input logic a_cv, input logic a_cb, input logic a_ss);
        iv = a_iv; id = a_id; cv = a_cv; cb = a_cb; ss = a_ss;
        @(posedge clk); #1;
        model_step(a_iv, a_id, a_cv, a_cb, a_ss);
        check_all();
    endtask

    task automatic do_reset();
        iv = 1'b0; id = 3'd0; cv = 1'b0; cb = 1'b0; ss = 1'b0;
        iv1 = 1'b0; id1 = 1'b0; cv1 = 1'b0; cb1 = 1'b0; ss1 = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_out_idx", oidx, 3'd0);
        chk("rst_out_y", oy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", ready, 1'b0);
        @(posedge clk); #1;
        chk("rst_ready_held", ready, 1'b0);
        rst = 1'b0;
    endtask

    task automatic load8(input logic [7:0] bits, input logic [7:0] gap_after);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 3'd0, 1'b1, bits[i], 1'b0);
            if (gap_after[i]) cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_sweep3(input logic [7:0] exp_tbl, input int exp_ones);
        int ones;
        ones = 0;
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
            chk("sweep_idx", oidx, k);
            chk("sweep_y", oy, exp_tbl[k]);
            chk("sweep_done_pos", done, (k == 7) ? 1 : 0);
            ones += int'(oy);
        end
`ifdef COMBO_LUT_SIGNATURE_EN
        chk("sig_ones_final", sig, exp_ones);
`endif
        chk("sweep_ones", ones, exp_ones);
        cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("post_sweep_valid", ov, 1'b0);
        chk("post_sweep_busy", busy, 1'b0);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        iv = 1'b0; id = 3'd0; cv = 1'b0; cb = 1'b0; ss = 1'b0;
        iv1 = 1'b0; id1 = 1'b0; cv1 = 1'b0; cb1 = 1'b0; ss1 = 1'b0;
        vecs[0] = '{3'd0, 1'b0}; vecs[1] = '{3'd1, 1'b1};
        vecs[2] = '{3'd2, 1'b1}; vecs[3] = '{3'd3, 1'b0};
        vecs[4] = '{3'd4, 1'b1}; vecs[5] = '{3'd5, 1'b0};
        vecs[6] = '{3'd6, 1'b0}; vecs[7] = '{3'd7, 1'b1};
        @(posedge clk); #1;
        do_reset();

        // Defaults after reset, then a lookup in the all-zero table
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("ready_after_release", ready, 1'b1);
        cyc(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        chk("init_y5", oy, 1'b0);

        // XOR3 with idle gaps, then table-driven back-to-back lookups
        load8(8'h96, 8'b0001_0100);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, vecs[i].din, 1'b0, 1'b0, 1'b0);
            chk("xor3_valid", ov, 1'b1);
            chk("xor3_idx", oidx, vecs[i].din);
            chk("xor3_y", oy, vecs[i].y);
        end

        // AND3 sweep with in_valid noise
        load8(8'h80, 8'h00);
        run_sweep3(8'h80, 1);

        // Load handshake wins over a same-cycle sweep_start; sweep_start in LOAD ignored
        cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
        chk("collide_busy", busy, 1'b0);
        chk("collide_ready", ready, 1'b1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("load_start_busy", busy, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("load_start_valid", ov, 1'b0);
        for (int i = 1; i < 8; i++) cyc(1'b0, 3'd0, 1'b1, (i == 7) ? 1'b1 : 1'b0, 1'b0);
        cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("and3_or_e0_y", oy, 1'b1);

        // Partial load: evaluation keeps the old table, reset discards the partial load
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("midload_old_table", oy, 1'b0);
        do_reset();
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        run_sweep3(8'h00, 0);

        // N_IN=1 NOT gate sweep; a second sweep_start while busy is dropped
        ss1 = 1'b1;
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("not_busy", busy1, 1'b1);
        chk("not_ready", ready1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        ss1 = 1'b0;
        chk("not_r0_valid", ov1, 1'b1);
        chk("not_r0_idx", oidx1, 1'b0);
        chk("not_r0_y", oy1, 1'b1);
        chk("not_r0_done", done1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("not_r1_valid", ov1, 1'b1);
        chk("not_r1_idx", oidx1, 1'b1);
        chk("not_r1_y", oy1, 1'b0);
        chk("not_r1_done", done1, 1'b1);
`ifdef COMBO_LUT_SIGNATURE_EN
        chk("not_sig", sig1, 2'd1);
`endif
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("not_end_valid", ov1, 1'b0);
        chk("not_end_busy", busy1, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("not_no_requeue", busy1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) do_reset();
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
